// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root sequencing controller.
package sqrt_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        CORR = 3'd3,
        DONE = 3'd4,
        FAIL = 3'd5
    } state_t;

    // Root update encodings seen by the DataPath on mux_root.
    localparam logic       ROOT_INC      = 1'b0;   // root + 1
    localparam logic       ROOT_SEL_CORR = 1'b1;   // root + ROOT_CORR
    localparam logic [7:0] ROOT_CORR     = 8'hFD;  // -3: undoes the pipeline overshoot

    localparam int DEF_MAX_ITER = 256;

endpackage

// File: rtl/sqrt_ctrl_if.sv
// Handshake and DataPath control bundle of the square-root controller.
interface sqrt_ctrl_if #(
    parameter int CNT_W = 9
);
    logic             start_i;
    logic             abort_i;
    logic             N_i;
    logic             wr_input_o;
    logic             wr_square_o;
    logic             en_pipe_o;
    logic             mux_root_o;
    logic             ready_dp_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [CNT_W-1:0] iter_o;

    // Controller side.
    modport slave (
        input  start_i, abort_i, N_i,
        output wr_input_o, wr_square_o, en_pipe_o, mux_root_o, ready_dp_o,
               busy_o, done_o, err_o, iter_o
    );

    // System / DataPath side.
    modport master (
        output start_i, abort_i, N_i,
        input  wr_input_o, wr_square_o, en_pipe_o, mux_root_o, ready_dp_o,
               busy_o, done_o, err_o, iter_o
    );
endinterface

// File: rtl/sqrt_iter_cnt.sv
// Saturating iteration counter with synchronous clear and terminal-count flag.
module sqrt_iter_cnt #(
    parameter int MAX_ITER = 256,
    parameter int CNT_W    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_ITER);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MAX_ITER - 1);
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // Count sampled iterations; hold at MAX_ITER instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    // High when the next increment reaches MAX_ITER.
    assign tc  = (cnt_r == LAST_C);

endmodule

// File: rtl/sqrt_ctrl.sv
// Sequencing FSM for the two-stage pipelined square-root DataPath.
module sqrt_ctrl
    import sqrt_pkg::*;
#(
    parameter int MAX_ITER = DEF_MAX_ITER,
    parameter int CNT_W    = 9
) (
    input  logic       clk,
    input  logic       rst,
    sqrt_ctrl_if.slave bus
);
    state_t           state_r, state_nxt_s;
    logic             phase_r, phase_nxt_s;
    logic             cnt_clr_s, cnt_en_s, tc_s;
    logic [CNT_W-1:0] cnt_s;

    logic wr_input_nxt_s, wr_square_nxt_s, en_pipe_nxt_s, mux_root_nxt_s;
    logic ready_nxt_s, busy_nxt_s, done_nxt_s, err_nxt_s;
    logic wr_input_r, wr_square_r, en_pipe_r, mux_root_r;
    logic ready_r, busy_r, done_r, err_r;

    sqrt_iter_cnt #(
        .MAX_ITER (MAX_ITER),
        .CNT_W    (CNT_W)
    ) u_iter_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr_s),
        .en  (cnt_en_s),
        .cnt (cnt_s),
        .tc  (tc_s)
    );

    // State and pipeline-phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            phase_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            phase_r <= phase_nxt_s;
        end
    end

    // Next-state logic; abort outranks both the N flag and the overflow check.
    always_comb begin
        state_nxt_s = state_r;
        phase_nxt_s = phase_r;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start_i) begin
                    state_nxt_s = LOAD;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (bus.abort_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ITER;
                    phase_nxt_s = 1'b0;
                end
            end
            ITER: begin
                if (bus.abort_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    phase_nxt_s = ~phase_r;
                    // N is only meaningful once the stage-2 result is valid.
                    if (phase_r) begin
                        cnt_en_s = 1'b1;
                        if (bus.N_i) begin
                            state_nxt_s = CORR;
                        end else if (tc_s) begin
                            state_nxt_s = FAIL;
                        end else begin
                            state_nxt_s = ITER;
                        end
                    end else begin
                        state_nxt_s = ITER;
                    end
                end
            end
            CORR: begin
                if (bus.abort_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            DONE:    state_nxt_s = IDLE;
            FAIL:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        wr_input_nxt_s  = 1'b0;
        wr_square_nxt_s = 1'b0;
        en_pipe_nxt_s   = 1'b0;
        mux_root_nxt_s  = ROOT_INC;
        ready_nxt_s     = 1'b0;
        done_nxt_s      = 1'b0;
        err_nxt_s       = 1'b0;
        case (state_nxt_s)
            IDLE: begin
            end
            LOAD: begin
                wr_input_nxt_s = 1'b1;
                en_pipe_nxt_s  = 1'b1;
            end
            ITER: begin
                en_pipe_nxt_s   = 1'b1;
                wr_square_nxt_s = phase_nxt_s;
            end
            CORR: begin
                en_pipe_nxt_s  = 1'b1;
                mux_root_nxt_s = ROOT_SEL_CORR;
            end
            DONE: begin
                done_nxt_s  = 1'b1;
                ready_nxt_s = 1'b1;
            end
            FAIL: begin
                err_nxt_s = 1'b1;
            end
            default: begin
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_input_r  <= 1'b0;
            wr_square_r <= 1'b0;
            en_pipe_r   <= 1'b0;
            mux_root_r  <= 1'b0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            wr_input_r  <= wr_input_nxt_s;
            wr_square_r <= wr_square_nxt_s;
            en_pipe_r   <= en_pipe_nxt_s;
            mux_root_r  <= mux_root_nxt_s;
            ready_r     <= ready_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

    assign bus.wr_input_o  = wr_input_r;
    assign bus.wr_square_o = wr_square_r;
    assign bus.en_pipe_o   = en_pipe_r;
    assign bus.mux_root_o  = mux_root_r;
    assign bus.ready_dp_o  = ready_r;
    assign bus.busy_o      = busy_r;
    assign bus.done_o      = done_r;
    assign bus.err_o       = err_r;
    assign bus.iter_o      = cnt_s;

endmodule

// File: tb/tb_sqrt_ctrl.sv
// Directed bench for sqrt_ctrl: FSM timing on a MAX_ITER=8 instance and an
// end-to-end root check on a default instance driving a behavioural DataPath.
module tb_sqrt_ctrl;
    import sqrt_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sqrt_ctrl_if #(.CNT_W(9)) a_if ();
    sqrt_ctrl_if #(.CNT_W(9)) b_if ();

    sqrt_ctrl #(.MAX_ITER(8), .CNT_W(9)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    sqrt_ctrl #(.MAX_ITER(256), .CNT_W(9)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    // Behavioural DataPath: root preloaded with the two-stage offset, N = valor < (root-1)^2
    // refreshed on phase-0 cycles, root advanced on phase-1 cycles, -3 on correction.
    logic [15:0] tb_valor;
    logic [15:0] dp_valor_r;
    logic [8:0]  dp_root_r;
    logic        dp_n_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valor_r <= 16'd0;
            dp_root_r  <= 9'd0;
            dp_n_r     <= 1'b0;
        end else if (b_if.wr_input_o) begin
            dp_valor_r <= tb_valor;
            dp_root_r  <= 9'd2;
            dp_n_r     <= 1'b0;
        end else if (b_if.en_pipe_o) begin
            if (b_if.mux_root_o) begin
                dp_root_r <= dp_root_r + {1'b1, ROOT_CORR};
            end else if (b_if.wr_square_o) begin
                dp_root_r <= dp_root_r + 9'd1;
            end else begin
                dp_n_r <= (32'(dp_valor_r) < (32'(dp_root_r) - 32'd1) * (32'(dp_root_r) - 32'd1));
            end
        end
    end

    assign b_if.N_i = dp_n_r;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [7:0] outs_a();
        return {a_if.wr_input_o, a_if.wr_square_o, a_if.en_pipe_o, a_if.mux_root_o,
                a_if.ready_dp_o, a_if.busy_o, a_if.done_o, a_if.err_o};
    endfunction

    // One run on dut_a: start at cycle 0, N first high at sample k (k=0: never).
    task automatic run_a(input int k, input int abort_at, input int restart_at, input bit n_glitch,
                         input int ncyc, output int done_at, output int done_cnt, output int err_at,
                         output int err_cnt, output int corr_at, output int idle_at,
                         output int wr_in_at, output logic [31:0] sq_pat);
        logic n;
        done_at = -1; done_cnt = 0; err_at = -1; err_cnt = 0;
        corr_at = -1; idle_at = -1; wr_in_at = -1; sq_pat = 32'd0;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) begin
                if (a_if.done_o) begin done_cnt++; if (done_at < 0) done_at = c; end
                if (a_if.err_o)  begin err_cnt++;  if (err_at < 0)  err_at  = c; end
                if (a_if.mux_root_o && corr_at < 0) corr_at = c;
                if (a_if.wr_input_o && wr_in_at < 0) wr_in_at = c;
                if (!a_if.busy_o && idle_at < 0 && c >= 2) idle_at = c;
                if (c < 32) sq_pat[c] = a_if.wr_square_o;
            end
            n = (k > 0) && (c >= 2 * k + 1);
            if (n_glitch && c >= 2 && (c % 2) == 0) n = 1'b1;
            a_if.start_i = (c == 0) || (c == restart_at);
            a_if.abort_i = (c == abort_at);
            a_if.N_i     = n;
            @(posedge clk); #1;
        end
        a_if.start_i = 1'b0;
        a_if.abort_i = 1'b0;
        a_if.N_i     = 1'b0;
    endtask

    // One end-to-end run on dut_b; returns the root seen while done_o is high.
    task automatic run_b(input logic [15:0] v, output int done_at, output logic [7:0] root,
                         output int iter);
        done_at = -1; root = 8'd0; iter = -1;
        tb_valor = v;
        for (int c = 0; c < 600; c++) begin
            if (c > 0 && b_if.done_o && b_if.ready_dp_o) begin
                done_at = c;
                root    = dp_root_r[7:0];
                iter    = int'(b_if.iter_o);
                b_if.start_i = 1'b0;
                @(posedge clk); #1;
                break;
            end
            b_if.start_i = (c == 0);
            @(posedge clk); #1;
        end
        b_if.start_i = 1'b0;
    endtask

    int          d_at, d_cnt, e_at, e_cnt, c_at, i_at, w_at, b_iter;
    logic [31:0] sq;
    logic [7:0]  b_root;

    initial begin
        rst = 1'b1;
        tb_valor = 16'd0;
        a_if.start_i = 1'b0; a_if.abort_i = 1'b0; a_if.N_i = 1'b0;
        b_if.start_i = 1'b0; b_if.abort_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", 32'(outs_a()), 32'd0);
        check_eq("reset_iter", 32'(a_if.iter_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // N seen at the first sample.
        run_a(1, -1, -1, 1'b0, 8, d_at, d_cnt, e_at, e_cnt, c_at, i_at, w_at, sq);
        check_eq("k1_wr_input_cycle", d_at < 0 ? 32'hFFFF_FFFF : 32'(w_at), 32'd1);
        check_eq("k1_corr_cycle", 32'(c_at), 32'd4);
        check_eq("k1_done_cycle", 32'(d_at), 32'd5);
        check_eq("k1_iter", 32'(a_if.iter_o), 32'd1);
        check_eq("k1_idle_cycle", 32'(i_at), 32'd6);

        // N first high at sample 5.
        run_a(5, -1, -1, 1'b0, 16, d_at, d_cnt, e_at, e_cnt, c_at, i_at, w_at, sq);
        check_eq("k5_done_cycle", 32'(d_at), 32'd13);
        check_eq("k5_wr_square_2to11", sq & 32'h0000_0FFC, 32'h0000_0AA8);
        check_eq("k5_iter", 32'(a_if.iter_o), 32'd5);
        check_eq("k5_done_count", 32'(d_cnt), 32'd1);

        // N never high: overflow at MAX_ITER=8.
        run_a(0, -1, -1, 1'b0, 22, d_at, d_cnt, e_at, e_cnt, c_at, i_at, w_at, sq);
        check_eq("ovf_err_cycle", 32'(e_at), 32'd18);
        check_eq("ovf_err_count", 32'(e_cnt), 32'd1);
        check_eq("ovf_no_done", 32'(d_cnt), 32'd0);
        check_eq("ovf_idle_cycle", 32'(i_at), 32'd19);
        check_eq("ovf_iter", 32'(a_if.iter_o), 32'd8);

        // Abort at cycle 6, then a fresh start at cycle 8.
        run_a(5, 6, -1, 1'b0, 8, d_at, d_cnt, e_at, e_cnt, c_at, i_at, w_at, sq);
        check_eq("abort_idle_cycle", 32'(i_at), 32'd7);
        check_eq("abort_no_done_err", 32'(d_cnt + e_cnt), 32'd0);
        check_eq("abort_iter_frozen", 32'(a_if.iter_o), 32'd2);
        run_a(2, -1, -1, 1'b0, 12, d_at, d_cnt, e_at, e_cnt, c_at, i_at, w_at, sq);
        check_eq("restart_done_cycle", 32'(d_at), 32'd7);
        check_eq("restart_iter", 32'(a_if.iter_o), 32'd2);

        // N pulsed on phase-0 cycles is ignored.
        run_a(4, -1, -1, 1'b1, 14, d_at, d_cnt, e_at, e_cnt, c_at, i_at, w_at, sq);
        check_eq("nglitch_done_cycle", 32'(d_at), 32'd11);
        check_eq("nglitch_iter", 32'(a_if.iter_o), 32'd4);

        // start during ITER is ignored.
        run_a(3, -1, 5, 1'b0, 20, d_at, d_cnt, e_at, e_cnt, c_at, i_at, w_at, sq);
        check_eq("sglitch_done_cycle", 32'(d_at), 32'd9);
        check_eq("sglitch_done_count", 32'(d_cnt), 32'd1);

        // start and abort together in IDLE: start wins.
        run_a(1, 0, -1, 1'b0, 8, d_at, d_cnt, e_at, e_cnt, c_at, i_at, w_at, sq);
        check_eq("start_over_abort_done", 32'(d_at), 32'd5);

        // Asynchronous reset in the middle of ITER.
        run_a(0, -1, -1, 1'b0, 5, d_at, d_cnt, e_at, e_cnt, c_at, i_at, w_at, sq);
        check_eq("pre_rst_busy_pipe", {30'd0, a_if.busy_o, a_if.en_pipe_o}, 32'd3);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_outputs", 32'(outs_a()), 32'd0);
        check_eq("async_rst_iter", 32'(a_if.iter_o), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_state", 32'(dut_a.state_r), 32'(IDLE));
        check_eq("post_rst_outputs", 32'(outs_a()), 32'd0);

        // End-to-end roots through the behavioural DataPath.
        run_b(16'd144, d_at, b_root, b_iter);
        check_eq("dp144_root", 32'(b_root), 32'd12);
        check_eq("dp144_done_cycle", 32'(d_at), 32'd29);
        check_eq("dp144_iter", 32'(b_iter), 32'd13);
        run_b(16'd0, d_at, b_root, b_iter);
        check_eq("dp0_root", 32'(b_root), 32'd0);
        check_eq("dp0_done_cycle", 32'(d_at), 32'd5);
        run_b(16'd65535, d_at, b_root, b_iter);
        check_eq("dp65535_root", 32'(b_root), 32'd255);
        check_eq("dp65535_iter", 32'(b_iter), 32'd256);
        check_eq("dp65535_no_err", 32'(b_if.err_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sqrt_ctrl.md
Name: sqrt_ctrl

Overview:
- Sequencing FSM for the two-stage pipelined square-root DataPath.
- Accepts a start request and drives the DataPath control inputs: wr_input, wr_square, en_pipe, ready, mux_root.
- Iterates on the DataPath N flag, issues one root-correction cycle, then reports completion.
- Adds an iteration guard, an abort path and a busy/done/err handshake toward the system.

Parameters:
- MAX_ITER, 256, maximum sampled iterations before err_o; must be ≥ 2^(root width) for 16-bit inputs.
- CNT_W, 9, iteration counter width; must hold MAX_ITER.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  request a new root computation; DataPath operand must be stable on valor_i this cycle.
- abort_i  in  1  cancel the running computation.
- N_i  in  1  DataPath N flag (input < square), registered in DataPath stage 2.
- wr_input_o  out  1  to DataPath wr_input_i; loads the operand.
- wr_square_o  out  1  to DataPath wr_square_i; selects the pipeline slot.
- en_pipe_o  out  1  to DataPath en_pipe_i; advances both pipeline stages.
- mux_root_o  out  1  to DataPath mux_root_i; 0 = root +1, 1 = correction addend 8'hFD.
- ready_dp_o  out  1  to DataPath ready_i.
- busy_o  out  1  high from the cycle after start acceptance until return to IDLE.
- done_o  out  1  one-cycle pulse; DataPath root_o is valid in this cycle.
- err_o  out  1  one-cycle pulse on iteration overflow.
- iter_o  out  CNT_W  sampled-iteration count of the current or last run.

Behaviour:
- Reset (async, rst=1): state=IDLE, phase=0, iter=0, all outputs 0.
- States: IDLE, LOAD, ITER, CORR, DONE, FAIL.
- IDLE:
  - All control outputs 0.
  - start_i=1 → LOAD; iter cleared.
  - start_i while not IDLE is ignored (no queueing).
- LOAD (1 cycle): wr_input_o=1, en_pipe_o=1, mux_root_o=0, wr_square_o=0 → ITER with phase=0.
- ITER:
  - en_pipe_o=1, mux_root_o=0, wr_square_o=phase; phase toggles every cycle.
  - When phase=1: N_i is sampled and iter increments.
    - N_i=1 → CORR.
    - N_i=0 and iter+1 == MAX_ITER → FAIL.
  - N_i is ignored when phase=0, because the pipeline result is not yet valid.
- CORR (1 cycle): en_pipe_o=1, mux_root_o=1 (root += -3, i.e. 8'hFD) → DONE.
- DONE (1 cycle): done_o=1, ready_dp_o=1, en_pipe_o=0 so root_o is held → IDLE.
- FAIL (1 cycle): err_o=1, en_pipe_o=0 → IDLE.
- busy_o=1 in LOAD, ITER, CORR, DONE and FAIL.
- Latency: start sampled at cycle 0; first N_i sample at cycle 3. If N_i is first seen high at sample k (cycle 2k+1), then CORR is at cycle 2k+2 and done_o at cycle 2k+3.
- Abort:
  - abort_i=1 in any non-IDLE state → IDLE next cycle; no done_o or err_o; iter_o frozen.
  - abort_i has priority over N_i and the overflow check.
  - abort_i in IDLE has no effect.
- Simultaneous start_i and abort_i in IDLE: start wins.
- iter saturates at MAX_ITER and never wraps; it holds its value through IDLE until the next start.
- rst mid-operation: immediate return to IDLE with all outputs 0; DataPath contents are don't-care.

Decomposition:
- Shared package sqrt_pkg holds:
  - state enum: IDLE, LOAD, ITER, CORR, DONE, FAIL;
  - ROOT_CORR constant 8'hFD and ROOT_INC encoding;
  - DEF_MAX_ITER = 256.
- One natural sub-module, sqrt_iter_cnt: saturating counter with clear, enable and terminal-count flag.
- FSM and output decode stay in sqrt_ctrl.

Test Plan:
- Reset then start_i at cycle 0, bench forces N_i=1 at the first sample → wr_input_o at cycle 1, CORR at cycle 4, done_o at cycle 5, iter_o=1.
- N_i first high at sample k=5 → done_o exactly at cycle 13; wr_square_o toggles 0,1 over cycles 2..11; iter_o=5.
- N_i held 0 with MAX_ITER=8 → err_o at cycle 18, no done_o, busy_o low at cycle 19, iter_o=8.
- abort_i at cycle 6 of a run → busy_o low at cycle 7, no done_o or err_o; a new start_i at cycle 8 completes normally.
- Glitches:
  - N_i pulsed high only during phase=0 cycles → ignored; run continues.
  - start_i pulsed during ITER → ignored; exactly one done_o.
- rst asserted asynchronously mid-ITER → all outputs 0 before the next clock edge; state is IDLE after release.
- Integrated with DataPath: valor=144 → root_o=12 at done_o; valor=0 → 0; valor=65535 → 255.
